match_counter_bank: RTL and testbench
=====================================

MATCH_COUNTER_BANK -- requirements
Module: match_counter_bank

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter width in bits (legal 8..64).
REQ-002 SHALL have parameter ADDR_W, default 4, counter index width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter SATURATE, default 1; 1 = hold at all-ones, 0 = wrap to zero.
REQ-004 SHALL have parameter CLEAR_ON_READ, default 0; 1 = a read zeroes the entry it returns.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 inc_valid_in  input  1  increment request for the entry at inc_addr_in.
REQ-009 inc_addr_in  input  ADDR_W  index of the entry to increment.
REQ-010 rd_req_in  input  1  read request for the entry at rd_addr_in.
REQ-011 rd_addr_in  input  ADDR_W  index of the entry to read.
REQ-012 clr_all_in  input  1  single-cycle pulse that starts a bulk clear of all entries.
REQ-013 rd_valid_out  output  1  one-cycle strobe qualifying rd_count_out.
REQ-014 rd_count_out  output  CNT_W  returned count; held between strobes.
REQ-015 busy_out  output  1  high while a bulk clear is running; requests are ignored.

Function
REQ-016 SHALL implement FSM states INIT and RUN; reset or clr_all_in (in RUN) -> INIT; INIT -> RUN after writing zero to entries 0..DEPTH-1, one entry per cycle in ascending order.
REQ-017 busy_out SHALL be high for exactly DEPTH cycles per INIT entry; inc_valid_in, rd_req_in and clr_all_in SHALL be ignored (not queued) while busy_out is high.
REQ-018 An increment accepted in cycle t SHALL be committed to storage by the rising edge ending cycle t+1; the increment pipeline has no stall and accepts one increment every cycle.
REQ-019 Back-to-back increments to the same index (any spacing, including consecutive cycles) SHALL all be counted; no increment is lost (read-after-write forwarding required).
REQ-020 Increments and reads SHALL NOT block each other; both may be accepted in the same cycle.
REQ-021 A read accepted in cycle t SHALL raise rd_valid_out in cycle t+2 with the count including every increment to that index accepted in cycles before t, and excluding any accepted in cycle t.
REQ-022 With CLEAR_ON_READ=1, the entry SHALL be zero after the read; an increment to the same index in cycle t SHALL land after the clear (entry = 1).
REQ-023 With SATURATE=1, an increment at all-ones SHALL leave the entry all-ones; with SATURATE=0 it SHALL wrap to zero.
REQ-024 Addition SHALL be CNT_W-bit unsigned with no carry out.
REQ-025 A read accepted in the last RUN cycle before clr_all_in takes effect SHALL still complete with pre-clear data.

Reset
REQ-026 During reset: rd_valid_out=0, rd_count_out=0, busy_out=1, pipelines flushed, in-flight increments and reads discarded.
REQ-027 After reset deasserts, SHALL be in INIT with the clear index at 0; storage contents are undefined until INIT completes.

Structure
REQ-028 Shared package SHALL hold the FSM state enumeration and the default values for CNT_W and ADDR_W.
REQ-029 Storage SHALL be one sub-module, counter_bank_ram: one synchronous write port, two synchronous read ports (increment path, read path), DEPTH x CNT_W.
REQ-030 Forwarding, saturation and FSM logic SHALL live in match_counter_bank; no other sub-modules.

Verification
REQ-031 Reset 1 cycle, then idle: busy_out high exactly 16 cycles (ADDR_W=4); afterwards reading all 16 entries returns 0.
REQ-032 inc_valid_in high for 5 consecutive cycles at index 3; read index 3 two cycles later -> rd_valid_out two cycles after request, rd_count_out=5.
REQ-033 Same cycle inc index 7 and read index 7 (entry previously 2) -> read returns 2; subsequent read returns 3; with CLEAR_ON_READ=1 the subsequent read returns 1.
REQ-034 CNT_W=8, entry preloaded by 255 increments, one more increment -> SATURATE=1 reads 255, SATURATE=0 reads 0.
REQ-035 clr_all_in pulse while increments stream to index 1 -> busy_out high 16 cycles, increments during busy ignored, index 1 reads 0 after.
REQ-036 Reset asserted mid-stream with a read outstanding -> no rd_valid_out pulse after reset; INIT restarts at index 0.

Source files
------------

// File: rtl/match_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : match_counter_bank_pkg
// Description : Shared FSM state type and default widths for match_counter_bank.
// Revision    : 1.0 - initial release
// ============================================================================
package match_counter_bank_pkg;

    localparam int c_DEFAULT_CNT_W  = 32;
    localparam int c_DEFAULT_ADDR_W = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank_ram
// Description : DEPTH x CNT_W storage, one synchronous write port and two
//               synchronous read ports (read-before-write on collisions).
// Revision    : 1.0 - initial release
// ============================================================================
module counter_bank_ram
    import match_counter_bank_pkg::*;
#(
    parameter int CNT_W  = c_DEFAULT_CNT_W,
    parameter int ADDR_W = c_DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [CNT_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic [CNT_W-1:0]  o_a_data,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic [CNT_W-1:0]  o_b_data
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [CNT_W-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_a_data <= r_mem[i_a_addr];
        o_b_data <= r_mem[i_b_addr];
    end

endmodule
`default_nettype wire

// File: rtl/match_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : match_counter_bank
// Description : Bank of 2**ADDR_W event counters with pipelined increment,
//               two-cycle read, optional saturation / clear-on-read, bulk clear.
// Revision    : 1.0 - initial release
// ============================================================================
module match_counter_bank
    import match_counter_bank_pkg::*;
#(
    parameter int CNT_W         = c_DEFAULT_CNT_W,
    parameter int ADDR_W        = c_DEFAULT_ADDR_W,
    parameter int SATURATE      = 1,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_valid_in,
    input  logic [ADDR_W-1:0] inc_addr_in,
    input  logic              rd_req_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic              clr_all_in,
    output logic              rd_valid_out,
    output logic [CNT_W-1:0]  rd_count_out,
    output logic              busy_out
);

    localparam int                c_DEPTH    = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  c_ALL_ONES = '1;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_idx;

    logic w_inc_acc;
    logic w_rd_acc;
    logic w_clr_acc;

    assign w_inc_acc = inc_valid_in && (r_state == ST_RUN);
    assign w_rd_acc  = rd_req_in    && (r_state == ST_RUN);
    assign w_clr_acc = clr_all_in   && (r_state == ST_RUN);

    // Control FSM: INIT sweeps zeros through every entry, one per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_clr_idx <= '0;
            busy_out  <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == c_LAST_IDX) begin
                        r_state  <= ST_RUN;
                        busy_out <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (clr_all_in) begin
                        r_state   <= ST_INIT;
                        r_clr_idx <= '0;
                        busy_out  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_clr_idx <= '0;
                    busy_out  <= 1'b1;
                end
            endcase
        end
    end

    // Storage write port (INIT sweep has priority over a dropped increment)
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [CNT_W-1:0]  w_wdata;
    logic [CNT_W-1:0]  w_ram_a_data;
    logic [CNT_W-1:0]  w_ram_b_data;

    counter_bank_ram #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_a_addr (inc_addr_in),
        .o_a_data (w_ram_a_data),
        .i_b_addr (rd_addr_in),
        .o_b_data (w_ram_b_data)
    );

    // Increment pipeline: stage 1 holds the accepted request plus a copy of
    // any write that the RAM read in the same cycle could not yet observe.
    logic              r_inc_v;
    logic [ADDR_W-1:0] r_inc_addr;
    logic              r_inc_byp;
    logic [CNT_W-1:0]  r_inc_byp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inc_v        <= 1'b0;
            r_inc_addr     <= '0;
            r_inc_byp      <= 1'b0;
            r_inc_byp_data <= '0;
        end else begin
            r_inc_v        <= w_inc_acc;
            r_inc_addr     <= inc_addr_in;
            r_inc_byp      <= w_we && (w_waddr == inc_addr_in);
            r_inc_byp_data <= w_wdata;
        end
    end

    logic             w_inc_zero;
    logic             w_rd_zero_now;
    logic [CNT_W-1:0] w_inc_base;
    logic [CNT_W-1:0] w_inc_next;

    // A pending clear-on-read marker overrides stale RAM/bypass data.
    assign w_inc_base = w_inc_zero ? '0 :
                        (r_inc_byp ? r_inc_byp_data : w_ram_a_data);
    assign w_inc_next = ((SATURATE != 0) && (w_inc_base == c_ALL_ONES)) ?
                        w_inc_base : (w_inc_base + CNT_W'(1));

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_inc_addr;
        w_wdata = w_inc_next;
        if (r_state == ST_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_clr_idx;
            w_wdata = '0;
        end else if (r_inc_v) begin
            w_we = 1'b1;
        end
    end

    // Clear-on-read is tracked as a per-entry "reads as zero" flag so the
    // single write port stays dedicated to increments.
    generate
        if (CLEAR_ON_READ != 0) begin : g_clear_on_read
            logic [c_DEPTH-1:0] r_zero;

            always_ff @(posedge clk) begin
                if (reset || w_clr_acc) begin
                    r_zero <= '0;
                end else begin
                    if (w_we) begin
                        r_zero[w_waddr] <= 1'b0;
                    end
                    if (w_rd_acc) begin
                        r_zero[rd_addr_in] <= 1'b1;
                    end
                end
            end

            assign w_inc_zero    = r_zero[r_inc_addr];
            assign w_rd_zero_now = r_zero[rd_addr_in];
        end else begin : g_no_clear_on_read
            assign w_inc_zero    = 1'b0;
            assign w_rd_zero_now = 1'b0;
        end
    endgenerate

    // Read pipeline: accept -> RAM/bypass select -> registered output.
    logic             r_rd_v;
    logic             r_rd_byp;
    logic [CNT_W-1:0] r_rd_byp_data;
    logic             r_rd_zero;
    logic [CNT_W-1:0] w_rd_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_v        <= 1'b0;
            r_rd_byp      <= 1'b0;
            r_rd_byp_data <= '0;
            r_rd_zero     <= 1'b0;
        end else begin
            r_rd_v        <= w_rd_acc;
            r_rd_byp      <= w_we && (w_waddr == rd_addr_in);
            r_rd_byp_data <= w_wdata;
            r_rd_zero     <= w_rd_zero_now;
        end
    end

    assign w_rd_value = r_rd_byp ? r_rd_byp_data :
                        (r_rd_zero ? '0 : w_ram_b_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_out <= 1'b0;
            rd_count_out <= '0;
        end else begin
            rd_valid_out <= r_rd_v;
            if (r_rd_v) begin
                rd_count_out <= w_rd_value;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_match_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_counter_bank
// Description : Self-checking bench driving three configurations of
//               match_counter_bank in lockstep against a per-entry count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_counter_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       inc_valid;
    logic [3:0] inc_addr;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       clr_all;

    logic        rdv_d, rdv_s, rdv_w;
    logic [31:0] cnt_d;
    logic [7:0]  cnt_s, cnt_w;
    logic        busy_d, busy_s, busy_w;

    always #5 clk = ~clk;

    match_counter_bank u_def (
        .clk (clk), .reset (reset),
        .inc_valid_in (inc_valid), .inc_addr_in (inc_addr),
        .rd_req_in (rd_req), .rd_addr_in (rd_addr), .clr_all_in (clr_all),
        .rd_valid_out (rdv_d), .rd_count_out (cnt_d), .busy_out (busy_d)
    );

    match_counter_bank #(.CNT_W(8), .ADDR_W(4), .SATURATE(1), .CLEAR_ON_READ(0)) u_s8 (
        .clk (clk), .reset (reset),
        .inc_valid_in (inc_valid), .inc_addr_in (inc_addr),
        .rd_req_in (rd_req), .rd_addr_in (rd_addr), .clr_all_in (clr_all),
        .rd_valid_out (rdv_s), .rd_count_out (cnt_s), .busy_out (busy_s)
    );

    match_counter_bank #(.CNT_W(8), .ADDR_W(4), .SATURATE(0), .CLEAR_ON_READ(1)) u_w8 (
        .clk (clk), .reset (reset),
        .inc_valid_in (inc_valid), .inc_addr_in (inc_addr),
        .rd_req_in (rd_req), .rd_addr_in (rd_addr), .clr_all_in (clr_all),
        .rd_valid_out (rdv_w), .rd_count_out (cnt_w), .busy_out (busy_w)
    );

    logic [63:0] o_cnt [3];
    logic        o_v   [3];
    logic        o_b   [3];

    always_comb begin
        o_cnt[0] = 64'(cnt_d);
        o_cnt[1] = 64'(cnt_s);
        o_cnt[2] = 64'(cnt_w);
        o_v[0]   = rdv_d;
        o_v[1]   = rdv_s;
        o_v[2]   = rdv_w;
        o_b[0]   = busy_d;
        o_b[1]   = busy_s;
        o_b[2]   = busy_w;
    end

    // Reference model: logical counter values per configuration.
    int              cw  [3] = '{32, 8, 8};
    bit              sat [3] = '{1'b1, 1'b1, 1'b0};
    bit              cor [3] = '{1'b0, 1'b0, 1'b1};
    longint unsigned m   [3][16];
    int              busy_left [3];
    bit              pv0 [3], pv1 [3];
    longint unsigned pd0 [3], pd1 [3], held [3];
    bit              model_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic longint unsigned maxv(input int k);
        return (64'd1 << cw[k]) - 64'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("busy%0d@%0d", k, cyc), 64'(o_b[k]), 64'(busy_left[k] > 0));
            check($sformatf("rdvalid%0d@%0d", k, cyc), 64'(o_v[k]), 64'(pv1[k]));
            check($sformatf("rdcount%0d@%0d", k, cyc), o_cnt[k], held[k]);
        end
    endtask

    task automatic model_edge(input bit rst, input bit iv, input int ia,
                              input bit rv, input int ra, input bit cl);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                busy_left[k] = 16;
                pv0[k] = 1'b0; pv1[k] = 1'b0; held[k] = 0;
                for (int j = 0; j < 16; j++) m[k][j] = 0;
            end else begin
                pv1[k] = pv0[k];
                pd1[k] = pd0[k];
                if (pv1[k]) held[k] = pd1[k];
                pv0[k] = 1'b0;
                if (busy_left[k] > 0) begin
                    busy_left[k]--;
                end else begin
                    if (rv) begin
                        pv0[k] = 1'b1;
                        pd0[k] = m[k][ra];
                        if (cor[k]) m[k][ra] = 0;
                    end
                    if (cl) begin
                        busy_left[k] = 16;
                        for (int j = 0; j < 16; j++) m[k][j] = 0;
                    end else if (iv) begin
                        if (m[k][ia] == maxv(k)) m[k][ia] = sat[k] ? maxv(k) : 0;
                        else                     m[k][ia] = m[k][ia] + 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit iv, input int ia,
                        input bit rv, input int ra, input bit cl);
        if (model_valid) check_all();
        reset     = rst;
        inc_valid = iv;
        inc_addr  = ia[3:0];
        rd_req    = rv;
        rd_addr   = ra[3:0];
        clr_all   = cl;
        @(posedge clk);
        model_edge(rst, iv, ia, rv, ra, cl);
        if (rst) model_valid = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_read(input string tag, input longint unsigned e0,
                               input longint unsigned e1, input longint unsigned e2);
        longint unsigned e [3];
        e = '{e0, e1, e2};
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_valid%0d", tag, k), 64'(o_v[k]), 64'd1);
            check($sformatf("%s_count%0d", tag, k), o_cnt[k], e[k]);
        end
    endtask

    initial begin
        reset = 1'b1; inc_valid = 1'b0; inc_addr = '0;
        rd_req = 1'b0; rd_addr = '0; clr_all = 1'b0;
        @(negedge clk);

        // One reset cycle, then the INIT sweep must keep busy high for 16 cycles
        step(1, 0, 0, 0, 0, 0);
        idle(16);
        for (int a = 0; a < 16; a++) step(0, 0, 0, 1, a, 0);
        idle(3);

        // Five back-to-back increments to index 3, read two cycles later
        for (int i = 0; i < 5; i++) step(0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_read("inc5", 5, 5, 5);

        // Same-cycle increment and read of index 7 holding 2
        step(0, 1, 7, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 1, 7, 0);
        step(0, 0, 0, 1, 7, 0);
        expect_read("same_cyc", 2, 2, 2);
        step(0, 0, 0, 0, 0, 0);
        expect_read("after_same", 3, 3, 1);
        idle(2);

        // 256 increments to index 9: saturate vs wrap at 8 bits
        for (int i = 0; i < 256; i++) step(0, 1, 9, 0, 0, 0);
        step(0, 0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_read("sat_wrap", 256, 255, 0);
        idle(2);

        // Bulk clear while increments stream to index 1, read in the clear cycle
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 1, 0, 0, 0);
        expect_read("preclear", 5, 5, 5);
        for (int i = 0; i < 15; i++) step(0, 1, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_read("postclear", 0, 0, 0);
        idle(2);

        // Randomized traffic concentrated on a few entries to stress forwarding
        for (int i = 0; i < 600; i++) begin
            int ia, ra;
            bit iv, rv, cl;
            iv = ($urandom % 4) != 0;
            rv = ($urandom % 3) != 0;
            cl = ($urandom % 80) == 0;
            ia = (($urandom % 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
            ra = (($urandom % 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
            step(0, iv, ia, rv, ra, cl);
        end
        idle(20);
        for (int a = 0; a < 16; a++) step(0, 0, 0, 1, a, 0);
        idle(3);

        // Reset with a read in flight: the read must never be reported
        step(0, 1, 2, 1, 2, 0);
        step(1, 1, 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_flush_valid%0d", k), 64'(o_v[k]), 64'd0);
            check($sformatf("rst_flush_count%0d", k), o_cnt[k], 64'd0);
            check($sformatf("rst_busy%0d", k), 64'(o_b[k]), 64'd1);
        end
        for (int i = 0; i < 18; i++) step(0, 1, 2, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_read("post_reset", 2, 2, 2);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
